// File: rtl/pgen_pkg.sv
// Shared constants and helpers for the N-phase pulse generator.
package pgen_pkg;

  localparam int DEFAULT_PHASES = 3;
  localparam int DEFAULT_DIV_W  = 8;

  // Width of a step index that covers 0 .. 2*phases-1.
  function automatic int step_w(input int phases);
    return $clog2(2 * phases);
  endfunction

endpackage

// File: rtl/pgen_tick.sv
// Step-period prescaler: counts enabled clocks and flags the clock on which a step advances.
module pgen_tick
  import pgen_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             rise
);

  logic             en_d_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_q_r;
  logic [DIV_W-1:0] div_eff_s;
  logic             rise_s;
  logic             tick_s;

  // On the first enabled clock the freshly loaded divisor already governs the step length.
  always_comb begin
    rise_s = en & ~en_d_r;
    if (rise_s) begin
      div_eff_s = div;
    end else begin
      div_eff_s = div_q_r;
    end
    tick_s = en & (cnt_r == div_eff_s);
  end

  assign tick = tick_s;
  assign rise = rise_s;

  // Prescaler count, enable history and divisor capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_r  <= 1'b0;
      cnt_r   <= {DIV_W{1'b0}};
      div_q_r <= {DIV_W{1'b0}};
    end else begin
      en_d_r <= en;
      if (!en) begin
        cnt_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + DIV_W'(1'b1);
      end
      if (tick_s | rise_s) begin
        div_q_r <= div;
      end
    end
  end

endmodule

// File: rtl/pgen_nphase.sv
// N-phase 50%-duty waveform generator: 2*PHASES steps per period, forward or reverse rotation.
module pgen_nphase
  import pgen_pkg::*;
#(
  parameter int PHASES = DEFAULT_PHASES,
  parameter int DIV_W  = DEFAULT_DIV_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        dir,
  input  logic [DIV_W-1:0]            div,
  output logic [PHASES-1:0]           phase_out,
  output logic [step_w(PHASES)-1:0]   step_idx,
  output logic                        step_stb,
  output logic                        sync
);

  localparam int            SW     = step_w(PHASES);
  localparam logic [SW-1:0] S_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] S_ONE  = SW'(1'b1);
  localparam logic [SW-1:0] S_LAST = SW'(2 * PHASES - 1);

  generate
    if (PHASES < 2 || PHASES > 8 || DIV_W < 1 || DIV_W > 16) begin : g_bad_param
      $error("pgen_nphase: PHASES must be 2..8 and DIV_W 1..16");
    end
  endgenerate

  // Phase k is high for the PHASES steps starting at step 2k.
  function automatic logic [PHASES-1:0] decode(input logic [SW-1:0] s);
    logic [PHASES-1:0] p;
    int                d;
    p = {PHASES{1'b0}};
    for (int k = 0; k < PHASES; k++) begin
      d    = (int'(s) + 2 * PHASES - 2 * k) % (2 * PHASES);
      p[k] = (d < PHASES);
    end
    return p;
  endfunction

  logic              tick_s;
  logic              rise_s;
  logic              dir_eff_s;
  logic [SW-1:0]     s_next_s;
  logic [SW-1:0]     s_r;
  logic              dir_q_r;
  logic [PHASES-1:0] phase_out_r;
  logic              step_stb_r;
  logic              sync_r;

  pgen_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .tick  (tick_s),
    .rise  (rise_s)
  );

  // Next step index; a direction change only takes effect once it has been captured.
  always_comb begin
    if (rise_s) begin
      dir_eff_s = dir;
    end else begin
      dir_eff_s = dir_q_r;
    end
    if (!tick_s) begin
      s_next_s = s_r;
    end else if (dir_eff_s == 1'b0) begin
      s_next_s = (s_r == S_LAST) ? S_ZERO : s_r + S_ONE;
    end else begin
      s_next_s = (s_r == S_ZERO) ? S_LAST : s_r - S_ONE;
    end
  end

  // Step state and registered outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r         <= S_ZERO;
      dir_q_r     <= 1'b0;
      phase_out_r <= {PHASES{1'b0}};
      step_stb_r  <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      s_r        <= s_next_s;
      step_stb_r <= tick_s;
      sync_r     <= tick_s & (s_next_s == S_ZERO);
      if (tick_s | rise_s) begin
        dir_q_r <= dir;
      end
      if (en) begin
        phase_out_r <= decode(s_next_s);
      end else begin
        phase_out_r <= {PHASES{1'b0}};
      end
    end
  end

  assign phase_out = phase_out_r;
  assign step_idx  = s_r;
  assign step_stb  = step_stb_r;
  assign sync      = sync_r;

endmodule

// File: tb/tb_pgen_nphase.sv
// Directed bench for pgen_nphase: a 3-phase instance for sequencing, a 4-phase instance for reset.
module tb_pgen_nphase;

  logic       clk = 1'b0;
  logic       rst_n_a;
  logic       rst_n_b;
  logic       en;
  logic       dir;
  logic [7:0] div;

  logic [2:0] ph_a;
  logic [2:0] idx_a;
  logic       stb_a;
  logic       sync_a;
  logic [3:0] ph_b;
  logic [2:0] idx_b;
  logic       stb_b;
  logic       sync_b;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [2:0] tbl [6];

  always #5 clk = ~clk;

  pgen_nphase #(.PHASES(3), .DIV_W(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n_a),
    .en        (en),
    .dir       (dir),
    .div       (div),
    .phase_out (ph_a),
    .step_idx  (idx_a),
    .step_stb  (stb_a),
    .sync      (sync_a)
  );

  pgen_nphase #(.PHASES(4), .DIV_W(8)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .en        (en),
    .dir       (dir),
    .div       (div),
    .phase_out (ph_b),
    .step_idx  (idx_b),
    .step_stb  (stb_b),
    .sync      (sync_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock on the 3-phase instance, then check every output.
  task automatic cyc(input string tag, input int s, input bit stb, input bit syn, input logic [2:0] ph);
    @(posedge clk);
    #1;
    chk({tag, "_idx"},   32'(idx_a),  32'(s));
    chk({tag, "_stb"},   32'(stb_a),  32'(stb));
    chk({tag, "_sync"},  32'(sync_a), 32'(syn));
    chk({tag, "_phase"}, 32'(ph_a),   32'(ph));
  endtask

  initial begin
    int s;
    bit stb;
    tbl = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    en      = 1'b0;
    dir     = 1'b0;
    div     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase_a", 32'(ph_a),   32'd0);
    chk("rst_idx_a",   32'(idx_a),  32'd0);
    chk("rst_stb_a",   32'(stb_a),  32'd0);
    chk("rst_sync_a",  32'(sync_a), 32'd0);
    chk("rst_phase_b", 32'(ph_b),   32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    cyc("idle", 0, 1'b0, 1'b0, 3'b000);

    // div=0: one step per clock, sync every 6 clocks
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc("fwd_div0", i % 6, 1'b1, (i % 6) == 0, tbl[i % 6]);
    end

    // div=3: first step still uses the old divisor, then 4 clocks per step
    div = 8'd3;
    cyc("div3_first", 1, 1'b1, 1'b0, tbl[1]);
    for (int i = 1; i <= 36; i++) begin
      s   = (1 + i / 4) % 6;
      stb = (i % 4) == 0;
      cyc("div3", s, stb, stb && (s == 0), tbl[s]);
    end

    // hold at step 4 for 10 clocks, then resume after div+1 enabled clocks
    en = 1'b0;
    repeat (10) cyc("hold", 4, 1'b0, 1'b0, 3'b000);
    en = 1'b1;
    repeat (3) cyc("resume", 4, 1'b0, 1'b0, tbl[4]);
    cyc("resume_adv", 5, 1'b1, 1'b0, tbl[5]);

    // mid-step dir and div change: current step keeps old settings
    dir = 1'b1;
    div = 8'd1;
    repeat (3) cyc("old_cfg", 5, 1'b0, 1'b0, tbl[5]);
    cyc("old_cfg_adv", 0, 1'b1, 1'b1, tbl[0]);
    for (int j = 1; j <= 12; j++) begin
      s   = (6 - j / 2) % 6;
      stb = (j % 2) == 0;
      cyc("rev_div1", s, stb, stb && (s == 0), tbl[s]);
    end
    cyc("rev_more", 0, 1'b0, 1'b0, tbl[0]);
    cyc("rev_more", 5, 1'b1, 1'b0, tbl[5]);

    // 4-phase instance: 24 forward, 7 reverse steps -> step 1
    chk("b_pre_idx",   32'(idx_b), 32'd1);
    chk("b_pre_phase", 32'(ph_b),  32'b1001);
    chk("b_pre_stb",   32'(stb_b), 32'd1);

    // asynchronous reset mid-step
    #2;
    rst_n_b = 1'b0;
    #1;
    chk("b_rst_idx",   32'(idx_b),  32'd0);
    chk("b_rst_phase", 32'(ph_b),   32'd0);
    chk("b_rst_stb",   32'(stb_b),  32'd0);
    chk("b_rst_sync",  32'(sync_b), 32'd0);
    @(posedge clk);
    #1;
    chk("b_rst_hold_phase", 32'(ph_b), 32'd0);
    rst_n_b = 1'b1;
    dir     = 1'b0;
    @(posedge clk);
    #1;
    chk("b_restart_idx",   32'(idx_b), 32'd0);
    chk("b_restart_phase", 32'(ph_b),  32'b1001);
    chk("b_restart_stb",   32'(stb_b), 32'd0);
    @(posedge clk);
    #1;
    chk("b_step1_idx",   32'(idx_b),  32'd1);
    chk("b_step1_stb",   32'(stb_b),  32'd1);
    chk("b_step1_sync",  32'(sync_b), 32'd0);
    chk("b_step1_phase", 32'(ph_b),   32'b1001);
    repeat (2) @(posedge clk);
    #1;
    chk("b_step2_idx",   32'(idx_b), 32'd2);
    chk("b_step2_stb",   32'(stb_b), 32'd1);
    chk("b_step2_phase", 32'(ph_b),  32'b0011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
